bin_to_bcd: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment display driver. It accepts a binary count over a valid/ready handshake and converts it with a shift-and-add-3 (double-dabble) loop, one bit per clock. It presents a packed BCD word, digit 0 in bits [3:0], in exactly the format the display driver multiplexes. Values above the displayable maximum saturate to all nines and raise a flag.

---
 rtl/bin_to_bcd_if.sv | 43 ++++
 rtl/bin_to_bcd.sv | 131 +++++++++++++
 tb/tb_bin_to_bcd.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_if.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_if
// Description : Handshake bundle between a binary producer, the bin_to_bcd
//               converter and the downstream display consumer.
//               Input side : in_valid / in_ready / in_data (binary value)
//               Output side: out_valid / out_ready / out_bcd / out_overflow
//               master = producer/consumer side, slave = converter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_if #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BIN_WIDTH-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*DIGITS-1:0]    out_bcd;
    logic                   out_overflow;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bcd,
        input  out_overflow
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bcd,
        output out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd
// Description : Sequential binary-to-BCD converter (shift-and-add-3), one
//               input bit per clock. Values above 10^DIGITS-1 saturate to
//               all nines and raise out_overflow.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low reset (0 = reset)
//   bus   : bin_to_bcd_if.slave - input handshake (in_valid/in_ready/in_data)
//           and output handshake (out_valid/out_ready/out_bcd/out_overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    bin_to_bcd_if.slave   bus
);

    function automatic longint unsigned f_max_val(input int digits);
        longint unsigned v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam longint unsigned MAX_VAL = f_max_val(DIGITS);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(BIN_WIDTH - 1);
    localparam logic [c_BCD_W-1:0] c_ALL_NINES = {DIGITS{4'h9}};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [BIN_WIDTH-1:0]  r_shift;
    logic [c_BCD_W-1:0]    r_acc;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_ovf;
    logic [c_BCD_W-1:0]    r_out_bcd;
    logic                  r_out_ovf;

    logic [c_BCD_W-1:0]    w_adj;
    logic [c_BCD_W-1:0]    w_acc_next;
    logic                  w_last;

    // Add-3 correction: a digit >= 5 would become >= 10 after doubling, so
    // pre-adding 3 makes the shift carry into the next digit. Max result 12,
    // so the 4-bit add never carries.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5) ?
                                      (r_acc[4*gi +: 4] + 4'd3) :
                                      r_acc[4*gi +: 4];
        end
    endgenerate

    // Shift {accumulator, shift register} left: binary MSB enters digit 0 bit 0.
    assign w_acc_next = {w_adj[c_BCD_W-2:0], r_shift[BIN_WIDTH-1]};
    assign w_last     = (r_cnt == c_CNT_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.in_valid)  w_state_next = c_ST_SHIFT;
            c_ST_SHIFT: if (w_last)        w_state_next = c_ST_DONE;
            c_ST_DONE:  if (bus.out_ready) w_state_next = c_ST_IDLE;
            default:                       w_state_next = c_ST_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_bcd <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_shift <= bus.in_data;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= (64'(bus.in_data) > MAX_VAL);
                    end
                end
                c_ST_SHIFT: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    // Result registers only change here, so they hold
                    // through DONE and after the output handshake.
                    if (w_last) begin
                        r_out_bcd <= r_ovf ? c_ALL_NINES : w_acc_next;
                        r_out_ovf <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = reset && (r_state == c_ST_IDLE);
    assign bus.out_valid    = (r_state == c_ST_DONE);
    assign bus.out_bcd      = r_out_bcd;
    assign bus.out_overflow = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd
// Description : Self-checking bench for bin_to_bcd with a cycle-level
//               behavioural reference model and randomized stream traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd;

    localparam int BW = 14;
    localparam int DG = 4;

    logic clk;
    logic reset;

    bin_to_bcd_if #(.BIN_WIDTH(BW), .DIGITS(DG)) bus ();

    bin_to_bcd #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits by plain arithmetic; saturate above 9999.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = 16'h9999;
        if (v <= 9999) begin
            p = 1;
            for (int i = 0; i < DG; i++) begin
                r[4*i +: 4] = 4'((v / p) % 10);
                p = p * 10;
            end
        end
        return r;
    endfunction

    // ---------------- Reference model ----------------
    bit          chk_en  = 0;
    bit          m_busy  = 0;
    bit          m_pend  = 0;
    int          m_left  = 0;
    int          m_val   = 0;
    logic [15:0] m_bcd   = '0;
    bit          m_ovf   = 0;
    bit          m_acc_evt = 0;
    int          m_nhs   = 0;
    int          n_hs    = 0;
    int          acc_q[$];

    always @(posedge clk) begin
        m_acc_evt = 0;
        if (!reset) begin
            m_busy = 0; m_pend = 0; m_left = 0;
            m_bcd = '0; m_ovf = 0;
            acc_q.delete();
            chk_en = 1;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_pend = 1;
                m_bcd  = to_bcd(m_val);
                m_ovf  = (m_val > 9999);
            end
        end else if (m_pend) begin
            if (bus.out_ready) begin
                m_pend = 0;
                m_nhs++;
            end
        end else if (bus.in_valid) begin
            m_busy = 1;
            m_left = BW;
            m_val  = int'(bus.in_data);
            m_acc_evt = 1;
            acc_q.push_back(m_val);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always begin
        @(posedge clk);
        #2;
        if (chk_en) begin
            chk("in_ready",     32'(bus.in_ready),     32'(reset && !m_busy && !m_pend));
            chk("out_valid",    32'(bus.out_valid),    32'(m_pend));
            chk("out_bcd",      32'(bus.out_bcd),      32'(m_bcd));
            chk("out_overflow", 32'(bus.out_overflow), 32'(m_ovf));
        end
    end

    // Output handshake monitor: each delivered result must match the oldest
    // accepted input (no loss, no duplication).
    always begin
        @(negedge clk);
        #1;
        if (chk_en && reset && bus.out_valid && bus.out_ready) begin
            n_hs++;
            if (acc_q.size() == 0) begin
                chk("hs_spurious", 32'(bus.out_bcd), 32'hFFFF_FFFF);
            end else begin
                chk("hs_value", 32'(bus.out_bcd), 32'(to_bcd(acc_q.pop_front())));
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input int v);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = BW'(v);
        for (int k = 0; k < 100; k++) begin
            tick();
            if (m_acc_evt) begin
                ok = 1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'(v), 32'hFFFF_FFFF);
    endtask

    // Directed conversion with out_ready high: checks exact latency literally.
    task automatic conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
        bus.out_ready = 1'b1;
        send(v);
        repeat (BW - 1) tick();
        chk("lat_early_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_valid",    32'(bus.out_valid),    32'd1);
        chk("lit_bcd",      32'(bus.out_bcd),      32'(exp_bcd));
        chk("lit_ovf",      32'(bus.out_overflow), 32'(exp_ovf));
        chk("done_inready", 32'(bus.in_ready),     32'd0);
        tick();
        chk("post_valid",   32'(bus.out_valid),    32'd0);
        chk("post_inready", 32'(bus.in_ready),     32'd1);
        chk("post_hold",    32'(bus.out_bcd),      32'(exp_bcd));
    endtask

    int vals[$];

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_inready", 32'(bus.in_ready),  32'd0);
        chk("rst_valid",   32'(bus.out_valid), 32'd0);
        chk("rst_bcd",     32'(bus.out_bcd),   32'd0);
        reset = 1'b1;
        tick();

        conv(0,     16'h0000, 1'b0);
        conv(1234,  16'h1234, 1'b0);
        conv(9999,  16'h9999, 1'b0);
        conv(10000, 16'h9999, 1'b1);
        conv(16383, 16'h9999, 1'b1);

        // Backpressure: result held, 777 not accepted while busy.
        bus.out_ready = 1'b0;
        send(42);
        repeat (BW) tick();
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_bcd",   32'(bus.out_bcd),   32'h0042);
            bus.in_valid = (i >= 5 && i < 8);
            bus.in_data  = BW'(777);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.in_ready),  32'd1);
        chk("bp_release_hold",  32'(bus.out_bcd),   32'h0042);

        // Reset in the middle of SHIFT drops the conversion.
        send(5678);
        repeat (7) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("midrst_valid", 32'(bus.out_valid), 32'd0);
            chk("midrst_bcd",   32'(bus.out_bcd),   32'd0);
            tick();
        end
        conv(5678, 16'h5678, 1'b0);

        // Randomized stream with random in_valid / out_ready.
        vals = '{0, 1, 9, 10, 99, 100, 999, 1000, 4095, 9998, 9999, 10000, 16383};
        for (int i = 0; i < 250; i++) vals.push_back(int'($urandom_range(0, 9999)));
        for (int i = 0; i < 20; i++)  vals.push_back(int'($urandom_range(10000, 16383)));
        begin
            int idx;
            int guard;
            idx = 0;
            guard = 0;
            while (idx < vals.size() && guard < 40000) begin
                bus.in_valid  = ($urandom_range(0, 1) == 1);
                bus.in_data   = BW'(vals[idx]);
                bus.out_ready = ($urandom_range(0, 4) != 0);
                tick();
                if (m_acc_evt) idx++;
                guard++;
            end
            if (idx < vals.size()) chk("stream_timeout", 32'(idx), 32'(vals.size()));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        begin
            int guard;
            guard = 0;
            while ((m_busy || m_pend) && guard < 100) begin
                tick();
                guard++;
            end
        end
        repeat (3) tick();
        chk("hs_count",    32'(n_hs),         32'(m_nhs));
        chk("queue_empty", 32'(acc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
